// File: rtl/instr_mem_loader.sv
// Run-time loadable instruction store with a one-cycle fetch port and fault reporting.
// Define BOOT_ROM_EN to come out of reset in RUN with a two-word boot program preset.
module instr_mem_loader #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 256,
  parameter int                    PC_WIDTH   = 32,
  parameter bit                    BYTE_ADDR  = 1'b1,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD   = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load_start,
  input  logic                    load_valid,
  input  logic [DATA_WIDTH-1:0]   load_data,
  input  logic                    load_done,
  output logic [$clog2(DEPTH):0]  load_count,
  output logic                    load_overflow,
  input  logic                    fetch_req,
  input  logic [PC_WIDTH-1:0]     pc,
  output logic                    fetch_ready,
  output logic [DATA_WIDTH-1:0]   instruction,
  output logic                    instr_valid,
  output logic                    fault_misaligned,
  output logic                    fault_range,
  output logic [1:0]              mem_state
);

  localparam int ADDR_WIDTH = $clog2(DEPTH);
  localparam int OFS_W      = $clog2(DATA_WIDTH / 8);

  localparam logic [ADDR_WIDTH:0]   FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [PC_WIDTH-1:0]   DEPTH_PC   = PC_WIDTH'(DEPTH);
  localparam logic [DATA_WIDTH-1:0] BOOT_WORD0 = DATA_WIDTH'(32'h8C01_0020);
  localparam logic [DATA_WIDTH-1:0] BOOT_WORD1 = DATA_WIDTH'(32'h8C02_0020);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_LOAD  = 2'b01,
    ST_RUN   = 2'b10
  } state_t;

  state_t state;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  fetch_accept;
  logic                  load_full;
  logic                  load_write;
  logic                  fetch_misaligned;
  logic                  fetch_out_of_range;
  logic [PC_WIDTH-1:0]   word_idx;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [ADDR_WIDTH-1:0] wr_addr;

  // Handshake: a fetch is accepted on any rising edge where fetch_ready and
  // fetch_req are both high; its result (instr_valid plus instruction and
  // faults) appears exactly one edge later. There is no back-pressure on the
  // result side, so the consumer must take instr_valid when it pulses.
  assign fetch_ready  = (state == ST_RUN);
  assign fetch_accept = fetch_ready && fetch_req;
  assign mem_state    = state;

  assign load_full  = (load_count == FULL_COUNT);
  // load_start in the same cycle restarts the load, so that cycle's word is dropped.
  assign load_write = (state == ST_LOAD) && load_valid && !load_start && !load_full;
  assign wr_addr    = load_count[ADDR_WIDTH-1:0];

  generate
    if (BYTE_ADDR && (OFS_W > 0)) begin : g_byte_addr
      assign word_idx         = pc >> OFS_W;
      assign fetch_misaligned = |pc[OFS_W-1:0];
    end else begin : g_word_addr
      assign word_idx         = pc;
      assign fetch_misaligned = 1'b0;
    end
  endgenerate

  // The whole index, upper pc bits included, is range checked so no fetch can alias.
  assign fetch_out_of_range = (word_idx >= DEPTH_PC);
  assign rd_addr            = word_idx[ADDR_WIDTH-1:0];

`ifdef BOOT_ROM_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem[0] <= BOOT_WORD0;
      mem[1] <= BOOT_WORD1;
    end else if (load_write) begin
      mem[wr_addr] <= load_data;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (load_write) begin
      mem[wr_addr] <= load_data;
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
`ifdef BOOT_ROM_EN
      state      <= ST_RUN;
      load_count <= (ADDR_WIDTH + 1)'(2);
`else
      state      <= ST_EMPTY;
      load_count <= '0;
`endif
      load_overflow    <= 1'b0;
      instruction      <= NOP_WORD;
      instr_valid      <= 1'b0;
      fault_misaligned <= 1'b0;
      fault_range      <= 1'b0;
    end else begin
      instr_valid      <= fetch_accept;
      fault_misaligned <= fetch_accept && fetch_misaligned;
      fault_range      <= fetch_accept && fetch_out_of_range;
      if (fetch_accept) begin
        instruction <= (fetch_misaligned || fetch_out_of_range) ? NOP_WORD : mem[rd_addr];
      end

      case (state)
        ST_EMPTY: begin
          if (load_start) begin
            state         <= ST_LOAD;
            load_count    <= '0;
            load_overflow <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (load_start) begin
            load_count    <= '0;
            load_overflow <= 1'b0;
          end else begin
            if (load_valid) begin
              if (load_full) begin
                load_overflow <= 1'b1;
              end else begin
                load_count <= load_count + 1'b1;
              end
            end
            if (load_done) begin
              state <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (load_start) begin
            state         <= ST_LOAD;
            load_count    <= '0;
            load_overflow <= 1'b0;
          end
        end
        default: begin
          state <= ST_EMPTY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader: load/fetch/fault/overflow/reset scenarios
// against a small memory model and an expected-result queue.
module tb_instr_mem_loader;

  localparam int          DW    = 32;
  localparam int          DEPTH = 4;
  localparam int          PCW   = 32;
  localparam logic [31:0] NOP   = 32'hFFFF_0000;
`ifdef BOOT_ROM_EN
  localparam bit BOOT = 1'b1;
`else
  localparam bit BOOT = 1'b0;
`endif

  localparam logic [1:0] S_EMPTY = 2'b00;
  localparam logic [1:0] S_LOAD  = 2'b01;
  localparam logic [1:0] S_RUN   = 2'b10;

  logic            clk;
  logic            reset;
  logic            load_start;
  logic            load_valid;
  logic [DW-1:0]   load_data;
  logic            load_done;
  logic [2:0]      load_count;
  logic            load_overflow;
  logic            fetch_req;
  logic [PCW-1:0]  pc;
  logic            fetch_ready;
  logic [DW-1:0]   instruction;
  logic            instr_valid;
  logic            fault_misaligned;
  logic            fault_range;
  logic [1:0]      mem_state;

  instr_mem_loader #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .PC_WIDTH   (PCW),
    .BYTE_ADDR  (1'b1),
    .NOP_WORD   (NOP)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .load_start       (load_start),
    .load_valid       (load_valid),
    .load_data        (load_data),
    .load_done        (load_done),
    .load_count       (load_count),
    .load_overflow    (load_overflow),
    .fetch_req        (fetch_req),
    .pc               (pc),
    .fetch_ready      (fetch_ready),
    .instruction      (instruction),
    .instr_valid      (instr_valid),
    .fault_misaligned (fault_misaligned),
    .fault_range      (fault_range),
    .mem_state        (mem_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- model and scoreboard ----------------
  logic [DW+1:0] exp_q[$];   // {range, misaligned, word}
  logic [DW-1:0] model_mem [DEPTH];
  int            model_count;
  bit            model_ovf;
  logic [1:0]    model_state;
  int            n_checks;
  int            n_pass;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic model_reset();
    model_state = BOOT ? S_RUN : S_EMPTY;
    model_count = BOOT ? 2 : 0;
    model_ovf   = 1'b0;
    if (BOOT) begin
      model_mem[0] = 32'h8C01_0020;
      model_mem[1] = 32'h8C02_0020;
    end
  endtask

  task automatic check_status(input string tag);
    check({tag, ".state"}, 64'(mem_state), 64'(model_state));
    check({tag, ".count"}, 64'(load_count), 64'(model_count));
    check({tag, ".ovf"}, 64'(load_overflow), 64'(model_ovf));
    check({tag, ".ready"}, 64'(fetch_ready), 64'(model_state == S_RUN));
  endtask

  // ---------------- driver tasks ----------------
  task automatic start_load();
    load_start = 1'b1;
    tick();
    load_start  = 1'b0;
    model_state = S_LOAD;
    model_count = 0;
    model_ovf   = 1'b0;
  endtask

  task automatic load_word(input logic [DW-1:0] data, input bit with_done);
    load_valid = 1'b1;
    load_data  = data;
    load_done  = with_done;
    tick();
    load_valid = 1'b0;
    load_done  = 1'b0;
    if (model_state == S_LOAD) begin
      if (model_count < DEPTH) begin
        model_mem[model_count] = data;
        model_count++;
      end else begin
        model_ovf = 1'b1;
      end
      if (with_done) model_state = S_RUN;
    end
  endtask

  task automatic finish_load();
    load_done = 1'b1;
    tick();
    load_done = 1'b0;
    if (model_state == S_LOAD) model_state = S_RUN;
  endtask

  function automatic logic [DW+1:0] expect_fetch(input logic [PCW-1:0] p);
    logic [PCW-1:0] idx;
    logic           mis;
    logic           rng;
    idx = p >> 2;
    mis = (p[1:0] != 2'b00);
    rng = (idx >= PCW'(DEPTH));
    return {rng, mis, (mis || rng) ? NOP : model_mem[idx[1:0]]};
  endfunction

  task automatic compare_output(input string tag);
    logic [DW+1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, ".valid"}, 64'(instr_valid), 64'(1));
      check({tag, ".instr"}, 64'(instruction), 64'(e[DW-1:0]));
      check({tag, ".faults"}, 64'({fault_range, fault_misaligned}), 64'(e[DW+1:DW]));
    end else begin
      check({tag, ".no_valid"}, 64'(instr_valid), 64'(0));
      check({tag, ".no_faults"}, 64'({fault_range, fault_misaligned}), 64'(0));
    end
  endtask

  task automatic fetch(input string tag, input logic [PCW-1:0] p);
    if (model_state == S_RUN) exp_q.push_back(expect_fetch(p));
    fetch_req = 1'b1;
    pc        = p;
    tick();
    fetch_req = 1'b0;
    compare_output(tag);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset      = 1'b1;
    load_start = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
    load_done  = 1'b0;
    fetch_req  = 1'b0;
    pc         = '0;
    n_checks   = 0;
    n_pass     = 0;
    model_reset();
    repeat (2) tick();
    reset = 1'b0;

    // Reset state, then a fetch that only the boot build accepts.
    check_status("rst");
    check("rst.instr", 64'(instruction), 64'(NOP));
    check("rst.valid", 64'(instr_valid), 64'(0));
    fetch("rst_fetch", 32'd0);
    tick();
    check("rst_fetch.pulse", 64'(instr_valid), 64'(0));

    // Basic load of three words, fetch ignored while loading.
    start_load();
    check_status("load_enter");
    fetch("fetch_in_load", 32'd0);
    load_word(32'h1111_1111, 1'b0);
    load_word(32'h2222_2222, 1'b0);
    load_word(32'h3333_3333, 1'b0);
    finish_load();
    check_status("load3");
    fetch("pc8", 32'd8);
    fetch("pc0", 32'd0);
    fetch("pc4", 32'd4);

    // Fault cases, including upper pc bits and both faults together.
    fetch("pc6_mis", 32'd6);
    fetch("pc16_rng", 32'd16);
    fetch("pc1024_rng", 32'd1024);
    fetch("pc_top_rng", 32'h8000_0000);
    fetch("pc17_both", 32'd17);
    finish_load();
    check_status("done_in_run");

    // Overflow: five words into a four-word array.
    start_load();
    load_word(32'hA0A0_A0A0, 1'b0);
    load_word(32'hA1A1_A1A1, 1'b0);
    load_word(32'hA2A2_A2A2, 1'b0);
    load_word(32'hA3A3_A3A3, 1'b0);
    load_word(32'hA4A4_A4A4, 1'b0);
    check_status("overflow");
    finish_load();
    fetch("pc12_last", 32'd12);
    start_load();
    check_status("ovf_clear");

    // Final word written in the same cycle as load_done.
    load_word(32'hD0D0_D0D0, 1'b0);
    load_word(32'hD1D1_D1D1, 1'b1);
    check_status("write_with_done");
    fetch("pc4_new", 32'd4);
    fetch("pc8_old", 32'd8);

    // Fetch accepted together with load_start returns the old word.
    exp_q.push_back(expect_fetch(32'd0));
    fetch_req  = 1'b1;
    pc         = 32'd0;
    load_start = 1'b1;
    tick();
    fetch_req   = 1'b0;
    load_start  = 1'b0;
    model_state = S_LOAD;
    model_count = 0;
    model_ovf   = 1'b0;
    compare_output("collide");
    check_status("collide");
    fetch("after_collide", 32'd4);

    // Asynchronous reset in the middle of a load.
    load_word(32'hB0B0_B0B0, 1'b0);
    load_word(32'hB1B1_B1B1, 1'b0);
    check_status("partial");
    #2 reset = 1'b1;
    #1 model_reset();
    check_status("async_rst");
    check("async_rst.instr", 64'(instruction), 64'(NOP));
    check("async_rst.valid", 64'(instr_valid), 64'(0));
    tick();
    reset = 1'b0;
    start_load();
    load_word(32'hC0C0_C0C0, 1'b1);
    check_status("reload");
    fetch("reload_pc0", 32'd0);
    fetch("reload_pc4", 32'd4);
    fetch("reload_pc8", 32'd8);
    fetch("reload_pc12", 32'd12);
    check("scoreboard_empty", 64'(exp_q.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
Parametrised successor to the single-cycle instruction store. Holds a program in a DEPTH x DATA_WIDTH array, loaded at run time through a streaming load port, with a fetch handshake. Byte or word PC addressing is selectable, and misaligned or out-of-range fetches raise faults. Sits between the PC register and the decode stage of the non-pipelined MIPS core; a testbench or boot loader drives the load port.

Parameters:
DATA_WIDTH, 32, instruction word width in bits; multiple of 8.
DEPTH, 256, number of instruction words; ADDR_WIDTH = $clog2(DEPTH) is a localparam.
PC_WIDTH, 32, width of the pc input.
BYTE_ADDR, 1, 1: pc is a byte address, word index = pc >> $clog2(DATA_WIDTH/8); 0: pc is the word index directly.
NOP_WORD, 0, value driven on instruction for a faulted or idle fetch.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
load_start  input  1  pulse: enter LOAD state, clear write pointer
load_valid  input  1  load_data is valid this cycle
load_data  input  DATA_WIDTH  word to write at the write pointer
load_done  input  1  pulse: end the load, enter RUN state
load_count  output  ADDR_WIDTH+1  number of words written since the last load_start
load_overflow  output  1  sticky: a write was attempted when the array was full
fetch_req  input  1  fetch request, sampled only when fetch_ready=1
pc  input  PC_WIDTH  fetch address
fetch_ready  output  1  high only in RUN state
instruction  output  DATA_WIDTH  fetched word, registered
instr_valid  output  1  one-cycle pulse marking instruction valid
fault_misaligned  output  1  fetch pc not word-aligned (BYTE_ADDR=1 only); pulses with instr_valid
fault_range  output  1  word index >= DEPTH; pulses with instr_valid
mem_state  output  2  00 EMPTY, 01 LOAD, 10 RUN

Behaviour:
- Reset (asynchronous):
  - mem_state=EMPTY, load_count=0, load_overflow=0, instruction=NOP_WORD, instr_valid=0, both fault outputs=0.
  - Array contents are not cleared.
- State transitions:
  - EMPTY: load_start -> LOAD.
  - LOAD: load_done -> RUN. load_start -> LOAD again, load_count=0, load_overflow=0.
  - RUN: load_start -> LOAD, load_count=0, load_overflow=0.
  - load_done outside LOAD is ignored.
  - load_start and load_done asserted together: load_start wins.
- Load writes:
  - In LOAD, load_valid writes mem[load_count] <= load_data and increments load_count.
  - If load_count==DEPTH, the write is dropped and load_overflow is set; it stays set until the next load_start or reset.
  - load_valid in the same cycle as load_done: the write happens, then the state goes to RUN.
  - load_valid outside LOAD is ignored.
- Fetch:
  - When fetch_ready=1 and fetch_req=1, the index is computed per BYTE_ADDR.
  - On the next edge: instr_valid=1 and instruction=mem[index]; latency is exactly 1 cycle.
  - Misaligned (pc[$clog2(DATA_WIDTH/8)-1:0] != 0 with BYTE_ADDR=1) or index >= DEPTH: instruction=NOP_WORD and the matching fault pulses with instr_valid. Both faults may assert together.
  - With no accepted request, instr_valid=0 and the fault outputs are 0; instruction holds its last value.
  - A fetch accepted in RUN in the same cycle as load_start completes normally with the old contents.
  - Fetches during EMPTY or LOAD are ignored; no instr_valid is produced.
  - The pc upper bits beyond the index width take part in the range check; they never wrap.
- A reset mid-load aborts the load: the state returns to EMPTY (BOOT_ROM_EN: RUN) and partially written words remain in the array.

Optional Feature:
BOOT_ROM_EN
- Defined:
  - Reset forces mem[0]=32'h8C010020 (lw $1,32($0)) and mem[1]=32'h8C020020 (lw $2,32($0)), zero-extended or truncated to DATA_WIDTH.
  - Reset sets mem_state=RUN and load_count=2, so the core runs the boot program with no load phase.
- Undefined: reset state is EMPTY and no words are preset.

Test Plan:
- Reset, then fetch_req with pc=0 -> no instr_valid, fetch_ready=0, mem_state=00 (BOOT_ROM_EN: instr_valid next cycle, instruction=8C010020).
- load_start, 3 x load_valid (11111111, 22222222, 33333333), load_done, fetch pc=8 (BYTE_ADDR=1) -> one cycle later instruction=33333333, instr_valid=1, load_count=3, mem_state=10.
- Fetch pc=6 -> instruction=NOP_WORD, fault_misaligned=1; fetch pc=1024 with DEPTH=256 -> fault_range=1.
- DEPTH=4: load 5 words -> load_count=4, load_overflow=1, mem[3] keeps the 4th word; a new load_start clears load_overflow.
- In RUN, fetch_req and load_start in the same cycle -> old word returned with instr_valid=1, state=LOAD, next fetch ignored.
- Assert reset during LOAD after 2 writes -> outputs at reset values immediately (asynchronously), mem_state=00; after reload, words beyond the new load keep their old data.
